// File: rtl/serial_add_sequencer.sv
// serial_add_sequencer: feeds two parallel operands LSB-first into an external
// 1-bit serial adder and reassembles the returned sum bits into a parallel
// WIDTH+1-bit result. The carry-out is captured in the MSB. Operands arrive over
// a valid/ready handshake, and the result leaves over another one. Only one
// operation is in flight at a time.
module serial_add_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             ser_clear,
    output logic             ser_a,
    output logic             ser_b,
    input  logic             ser_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_sum
);

    // The counter must be able to hold the value WIDTH. That value marks the
    // extra cycle that collects the carry-out.
    localparam int              CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sa_q;
    logic [WIDTH-1:0] sb_q;
    logic [WIDTH:0]   res_q;
    logic [CW-1:0]    cnt_q;

    // Sequencer FSM plus its datapath. Reset is synchronous and wins over any handshake.
    always_ff @(posedge clk) begin
        // NOTE: all state here updates with non-blocking assignments, so every
        // register sees the pre-edge values of the others. For example, res_q
        // captures the ser_sum produced from the old sa_q/sb_q bits.
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
            sa_q    <= '0;
            sb_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // in_ready is exactly (state_q == IDLE), so in_valid alone completes the handshake.
                    if (in_valid) begin
                        sa_q    <= in_a;
                        sb_q    <= in_b;
                        cnt_q   <= '0;
                        res_q   <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Sum bits enter at the MSB and move down. After WIDTH+1
                    // cycles, bit 0 of the operands sits at res_q[0] and the
                    // carry-out sits at res_q[WIDTH].
                    res_q <= {ser_sum, res_q[WIDTH:1]};
                    sa_q  <= sa_q >> 1;
                    sb_q  <= sb_q >> 1;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Output decode depends only on registered state, so no input reaches an output combinationally.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    // The adder carry stays cleared outside SHIFT. Every operation therefore starts with carry 0.
    assign ser_clear = (state_q != SHIFT);
    assign ser_a     = (state_q == SHIFT) & sa_q[0];
    assign ser_b     = (state_q == SHIFT) & sb_q[0];
    assign out_sum   = res_q;

endmodule
